// File: rtl/name_entry_renderer_pkg.sv
// Shared display definitions for the high-score name-entry screen:
// glyph cell geometry, ROM code bases, colour type and entry state.
package name_entry_renderer_pkg;

    localparam int GLYPH_W     = 5;
    localparam int GLYPH_H     = 7;
    localparam int DIGIT_BASE  = 0;
    localparam int LETTER_BASE = 10;

    typedef logic [11:0] rgb444_t;

    typedef enum logic {
        EDIT = 1'b0,
        DONE = 1'b1
    } ne_state_t;

endpackage

// File: rtl/name_entry_renderer_ctrl.sv
// Name-entry control: button FSM, cursor, character code registers and
// the cursor blink timer.
module name_entry_ctrl
    import name_entry_renderer_pkg::*;
#(
    parameter int NUM_CHARS    = 3,
    parameter int ALPHABET     = 26,
    parameter int BLINK_FRAMES = 30,
    parameter int CW           = $clog2(NUM_CHARS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_confirm,
    output logic [5*NUM_CHARS-1:0]   player_name,
    output logic [CW-1:0]            cursor_pos,
    output logic                     name_done,
    output logic                     blink_on
);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    ne_state_t                   state_q, state_d;
    logic [CW-1:0]               cursor_q, cursor_d;
    logic [0:NUM_CHARS-1][4:0]   code_q, code_d;
    logic                        blink_q, blink_d;
    logic [FW-1:0]               fcnt_q, fcnt_d;
    logic                        at_char;
    logic                        act;

    function automatic logic [4:0] code_inc(input logic [4:0] c);
        return (c == 5'(ALPHABET - 1)) ? 5'd0 : c + 5'd1;
    endfunction

    function automatic logic [4:0] code_dec(input logic [4:0] c);
        return (c == 5'd0) ? 5'(ALPHABET - 1) : c - 5'd1;
    endfunction

    function automatic logic [CW-1:0] cur_inc(input logic [CW-1:0] c);
        return (c == CW'(NUM_CHARS)) ? '0 : c + CW'(1);
    endfunction

    function automatic logic [CW-1:0] cur_dec(input logic [CW-1:0] c);
        return (c == '0) ? CW'(NUM_CHARS) : c - CW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EDIT;
            cursor_q <= '0;
            code_q   <= '0;
            blink_q  <= 1'b1;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            code_q   <= code_d;
            blink_q  <= blink_d;
            fcnt_q   <= fcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        code_d   = code_q;
        blink_d  = blink_q;
        fcnt_d   = fcnt_q;
        act      = 1'b0;
        at_char  = (cursor_q != CW'(NUM_CHARS));

        if (frame_start) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                blink_d = !blink_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        // One action per cycle; the if/else chain encodes the priority.
        if (state_q == EDIT) begin
            if (btn_confirm) begin
                if (at_char) begin
                    cursor_d = cur_inc(cursor_q);
                    act      = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end else if (btn_left) begin
                cursor_d = cur_dec(cursor_q);
                act      = 1'b1;
            end else if (btn_right) begin
                cursor_d = cur_inc(cursor_q);
                act      = 1'b1;
            end else if (btn_up || btn_down) begin
                for (int i = 0; i < NUM_CHARS; i++) begin
                    if (cursor_q == CW'(i)) begin
                        code_d[i] = btn_up ? code_inc(code_q[i]) : code_dec(code_q[i]);
                        act       = 1'b1;
                    end
                end
            end
        end

        if (act) begin
            blink_d = 1'b1;
            fcnt_d  = '0;
        end
    end

    assign player_name = code_q;
    assign cursor_pos  = cursor_q;
    assign name_done   = (state_q == DONE);
    assign blink_on    = blink_q || (state_q == DONE);

endmodule

// File: rtl/name_entry_renderer.sv
// Name-entry layer: decodes glyph and cursor-frame regions from the pixel
// counters and produces a 2-cycle registered pixel through the glyph ROM.
module name_entry_renderer
    import name_entry_renderer_pkg::*;
#(
    parameter int      NUM_CHARS    = 3,
    parameter int      ALPHABET     = 26,
    parameter int      GLYPH_BASE   = LETTER_BASE,
    parameter int      SCALE_SHIFT  = 4,
    parameter int      ORIGIN_X     = 190,
    parameter int      ORIGIN_Y     = 38,
    parameter int      PITCH        = 90,
    parameter int      BORDER       = 10,
    parameter int      BLINK_FRAMES = 30,
    parameter rgb444_t CURSOR_COLOR = 12'hfff
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame_start,
    input  logic                               btn_left,
    input  logic                               btn_right,
    input  logic                               btn_up,
    input  logic                               btn_down,
    input  logic                               btn_confirm,
    input  logic [9:0]                         h_cnt,
    input  logic [9:0]                         v_cnt,
    output logic [5:0]                         txt_addr,
    output logic [2:0]                         h_point,
    output logic [2:0]                         v_point,
    input  rgb444_t                            txt_pixel,
    output logic [5*NUM_CHARS-1:0]             player_name,
    output logic [$clog2(NUM_CHARS+1)-1:0]     cursor_pos,
    output logic                               name_done,
    output rgb444_t                            pixel_out,
    output logic                               valid
);
    localparam int CW     = $clog2(NUM_CHARS + 1);
    localparam int GW     = GLYPH_W << SCALE_SHIFT;
    localparam int GH     = GLYPH_H << SCALE_SHIFT;
    localparam int SPAN_W = (NUM_CHARS - 1) * PITCH + GW;

    logic        blink_on;
    logic [11:0] x, y, fl, fw, gx;
    logic        in_rows, in_ring_rows, in_outer, in_inner;
    logic        glyph_hit_p0, frame_hit_p0;
    logic        glyph_hit_p1_q, frame_hit_p1_q;
    rgb444_t     pixel_p2_d, pixel_p2_q;
    logic        vld_p2_d, vld_p2_q;

    name_entry_ctrl #(
        .NUM_CHARS    (NUM_CHARS),
        .ALPHABET     (ALPHABET),
        .BLINK_FRAMES (BLINK_FRAMES),
        .CW           (CW)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_confirm (btn_confirm),
        .player_name (player_name),
        .cursor_pos  (cursor_pos),
        .name_done   (name_done),
        .blink_on    (blink_on)
    );

    assign x = {2'b00, h_cnt};
    assign y = {2'b00, v_cnt};

    // Stage 0: region decode. Ring tests add BORDER to the pixel side so
    // a border larger than the origin cannot underflow.
    always_comb begin
        glyph_hit_p0 = 1'b0;
        txt_addr     = '0;
        h_point      = '0;
        v_point      = '0;
        gx           = '0;
        if (cursor_pos == CW'(NUM_CHARS)) begin
            fl = 12'(ORIGIN_X);
            fw = 12'(SPAN_W);
        end else begin
            fl = 12'(ORIGIN_X) + 12'(cursor_pos) * 12'(PITCH);
            fw = 12'(GW);
        end
        in_rows      = (y >= 12'(ORIGIN_Y)) && (y < 12'(ORIGIN_Y + GH));
        in_ring_rows = (y + 12'(BORDER) >= 12'(ORIGIN_Y)) && (y < 12'(ORIGIN_Y + GH + BORDER));
        in_outer     = in_ring_rows && (x + 12'(BORDER) >= fl) && (x < fl + fw + 12'(BORDER));
        in_inner     = in_rows && (x >= fl) && (x < fl + fw);
        frame_hit_p0 = blink_on && in_outer && !in_inner;

        for (int i = 0; i < NUM_CHARS; i++) begin
            if (in_rows && (x >= 12'(ORIGIN_X + i * PITCH)) && (x < 12'(ORIGIN_X + i * PITCH + GW))) begin
                gx           = 12'(ORIGIN_X + i * PITCH);
                glyph_hit_p0 = 1'b1;
                txt_addr     = 6'(player_name[5*(NUM_CHARS-1-i) +: 5]) + 6'(GLYPH_BASE);
            end
        end

        if (frame_hit_p0) begin
            glyph_hit_p0 = 1'b0;
            txt_addr     = '0;
        end else if (glyph_hit_p0) begin
            h_point = 3'((x - gx) >> SCALE_SHIFT);
            v_point = 3'((y - 12'(ORIGIN_Y)) >> SCALE_SHIFT);
        end
    end

    // Stage 1: hit flags travel alongside the ROM read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glyph_hit_p1_q <= 1'b0;
            frame_hit_p1_q <= 1'b0;
        end else begin
            glyph_hit_p1_q <= glyph_hit_p0;
            frame_hit_p1_q <= frame_hit_p0;
        end
    end

    always_comb begin
        pixel_p2_d = '0;
        vld_p2_d   = 1'b0;
        if (frame_hit_p1_q) begin
            pixel_p2_d = CURSOR_COLOR;
            vld_p2_d   = 1'b1;
        end else if (glyph_hit_p1_q) begin
            pixel_p2_d = txt_pixel;
            vld_p2_d   = 1'b1;
        end
    end

    // Stage 2: registered layer output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_p2_q <= '0;
            vld_p2_q   <= 1'b0;
        end else begin
            pixel_p2_q <= pixel_p2_d;
            vld_p2_q   <= vld_p2_d;
        end
    end

    assign pixel_out = pixel_p2_q;
    assign valid     = vld_p2_q;

endmodule

// File: doc/name_entry_renderer.md
Name: name_entry_renderer

Overview:
Parametrised name-entry block for the high-score screen. It owns the editable N-character player name and the cursor position, driven by debounced button pulses. It renders the name glyphs and a blinking cursor frame into the VGA pixel stream through a 1-cycle glyph ROM, with a fixed registered pixel latency. It sits between the input debouncers, the VGA timing counters and the score/leaderboard logic, which consumes player_name and name_done.

Parameters:
NUM_CHARS, 3, number of name characters (1..8)
ALPHABET, 26, legal character codes 0..ALPHABET-1
GLYPH_BASE, 10, ROM address of code 0 (ROM addresses 0..9 are digits)
SCALE_SHIFT, 4, glyph cell size in pixels = 1<<SCALE_SHIFT
ORIGIN_X, 190, left edge of character 0
ORIGIN_Y, 38, top edge of the glyph row
PITCH, 90, horizontal distance between character origins
BORDER, 10, cursor frame thickness in pixels
BLINK_FRAMES, 30, frames per blink half-period
CURSOR_COLOR, 12'hfff, frame colour

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous reset, active low
frame_start  in  1  one-cycle pulse at start of each frame
btn_left, btn_right, btn_up, btn_down, btn_confirm  in  1 each  one-cycle debounced pulses
h_cnt  in  10  current pixel column
v_cnt  in  10  current pixel row
txt_addr  out  6  glyph ROM address
h_point  out  3  glyph cell column 0..4
v_point  out  3  glyph cell row 0..6
txt_pixel  in  12  glyph ROM data, valid 1 cycle after address
player_name  out  5*NUM_CHARS  codes packed, char 0 in MSBs
cursor_pos  out  $clog2(NUM_CHARS+1)  0..NUM_CHARS-1 = a character; NUM_CHARS = "whole name" / confirm slot
name_done  out  1  high while in DONE
pixel_out  out  12  RGB444
valid  out  1  pixel_out belongs to this layer

Behaviour:
- Reset (rst_n=0 at clk edge): state EDIT, all char codes 0, cursor_pos 0, blink_on 1, frame counter 0, name_done 0, pixel_out 0, valid 0, pipeline flags cleared. Reset mid-frame is legal; output is valid-low until the pipeline refills (2 cycles).
- FSM EDIT: at most one action per cycle, priority confirm > left > right > up > down; all other pulses that cycle are dropped.
  - left: cursor-1, 0 wraps to NUM_CHARS.
  - right: cursor+1, NUM_CHARS wraps to 0.
  - up/down: only when cursor<NUM_CHARS; code +1/-1 mod ALPHABET (ALPHABET-1->0, 0->ALPHABET-1). Ignored at cursor NUM_CHARS.
  - confirm: at cursor<NUM_CHARS acts as right. At cursor==NUM_CHARS goes to DONE.
- FSM DONE: name_done=1; all buttons ignored; name and cursor frozen. Exit only by reset.
- Blink: count frame_start pulses. After BLINK_FRAMES pulses, toggle blink_on and clear the counter. Any cursor move or code change sets blink_on=1 and clears the counter that cycle. In DONE, blink_on is forced 1.
- Geometry: glyph i occupies x in [ORIGIN_X+i*PITCH, +5<<SCALE_SHIFT) and y in [ORIGIN_Y, +7<<SCALE_SHIFT).
  - Frame for cursor i is the ring of width BORDER around glyph i.
  - Frame for cursor NUM_CHARS is the ring around the span from glyph 0 to glyph NUM_CHARS-1.
  - The frame is drawn only when blink_on.
- Stage 0 (combinational from h_cnt/v_cnt): decode region.
  - Glyph hit: txt_addr = code+GLYPH_BASE; h_point/v_point = offset>>SCALE_SHIFT.
  - Otherwise txt_addr/h_point/v_point = 0.
  - Frame hit takes priority over glyph hit.
- Stage 1: register glyph_hit and frame_hit alongside the ROM access.
- Stage 2 (registered outputs):
  - frame_hit: pixel_out=CURSOR_COLOR, valid=1.
  - glyph_hit: pixel_out=txt_pixel, valid=1.
  - Else: pixel_out=0, valid=0.
- Total latency from h_cnt/v_cnt to pixel_out/valid is exactly 2 clk. The caller pre-offsets counters accordingly.
- Name or cursor changes take effect on the first pixel sampled after the update edge; partial-frame tearing is acceptable.
- All geometry arithmetic is at least 11-bit unsigned, so ORIGIN+offset never wraps for 640x480.

Decomposition:
- Shared package (display pkg): glyph width/height in cells (5, 7), letter/digit base codes, RGB444 typedef, name-entry state enum {EDIT, DONE}.
- One sub-module, name_entry_ctrl: FSM, cursor, code registers and blink counter. The parent keeps geometry decode and the pixel pipeline.
- The glyph ROM (memory_txt) is instantiated by the parent, outside this block.

Test Plan:
- Reset, then idle -> player_name=0, cursor_pos=0, name_done=0. Pixel (190,38) after 2 clk gives valid=1, pixel=ROM data for addr 10, h_point=0, v_point=0.
- up x27 at cursor 0 -> code0=1 (wraps through 25->0). down once from 0 -> 25; player_name[14:10]=25.
- left from cursor 0 -> cursor=3 (NUM_CHARS=3). Pixel (180,100) -> CURSOR_COLOR while blink_on; pixel (185,100) at cursor 1 -> valid=0.
- Same-cycle confirm+up at cursor 1 -> cursor=2, codes unchanged. left+right together -> cursor-1 only.
- Cursor 3, confirm -> name_done=1 next cycle. Subsequent up/left leave name and cursor unchanged. Frame stays steady across 100 frame_start pulses.
- 30 frame_start pulses with no input -> blink_on toggles to 0 and the frame pixels give valid=0. A right press sets blink_on=1 immediately.
